// File: rtl/shift_feeder_pkg.sv
// Shared types and constants for the shift_feeder serialiser.
// The PARITY state only becomes reachable when SHIFT_FEEDER_PARITY_EN is defined.
package shift_feeder_pkg;

  localparam int DEFAULT_NBITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/shift_feeder_bitcnt.sv
// Bit counter for one serialised word.
// It saturates at NBITS so it never wraps inside a word, and flags the final data bit.
module shift_feeder_bitcnt #(
  parameter int NBITS = 8,
  parameter int CW    = $clog2(NBITS + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(NBITS))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: the bit being emitted at this edge is the last data bit.
  assign last_o = (cnt_q == CW'(NBITS - 1));

endmodule

// File: rtl/shift_feeder.sv
// Parallel-to-serial feeder for a downstream shift register, one bit per CE strobe.
// Define SHIFT_FEEDER_PARITY_EN to append an even-parity bit after each word.
module shift_feeder
  import shift_feeder_pkg::*;
#(
  parameter int NBITS     = DEFAULT_NBITS,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [NBITS-1:0] D,
  input  logic             VALID,
  output logic             READY,
  input  logic             CE,
  output logic             SO,
  output logic             SO_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(NBITS + 1);

  state_e           state_q;
  logic [NBITS-1:0] sreg_q;
  logic [NBITS-1:0] sreg_d;
  logic             so_q;
  logic             so_valid_q;
  logic             done_q;
  logic             end_bit;
  logic             handshake;
  logic             bit_ev;
  logic             cnt_last;
`ifdef SHIFT_FEEDER_PARITY_EN
  logic             parity_q;
`endif

  assign READY     = (state_q == IDLE);
  assign BUSY      = ~READY;
  assign handshake = VALID & READY;
  assign bit_ev    = (state_q == SHIFT) & CE;

  // The emitted end bit is consumed and the register moves one place toward it.
  assign end_bit = MSB_FIRST ? sreg_q[NBITS-1] : sreg_q[0];
  assign sreg_d  = MSB_FIRST ? {sreg_q[NBITS-2:0], 1'b0} : {1'b0, sreg_q[NBITS-1:1]};

  shift_feeder_bitcnt #(
    .NBITS(NBITS),
    .CW   (CW)
  ) u_bitcnt (
    .clk_i (C),
    .rst_ni(CLR_N),
    .clr_i (handshake),
    .inc_i (bit_ev),
    .last_o(cnt_last)
  );

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SHIFT_FEEDER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      so_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (VALID) begin
            sreg_q  <= D;
            state_q <= SHIFT;
`ifdef SHIFT_FEEDER_PARITY_EN
            parity_q <= ^D;
`endif
          end
        end
        SHIFT: begin
          if (CE) begin
            so_q       <= end_bit;
            so_valid_q <= 1'b1;
            sreg_q     <= sreg_d;
            if (cnt_last) begin
`ifdef SHIFT_FEEDER_PARITY_EN
              state_q <= PARITY;
`else
              done_q  <= 1'b1;
              state_q <= IDLE;
`endif
            end
          end
        end
`ifdef SHIFT_FEEDER_PARITY_EN
        PARITY: begin
          if (CE) begin
            so_q       <= parity_q;
            so_valid_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SO       = so_q;
  assign SO_VALID = so_valid_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench for shift_feeder: an MSB-first and an LSB-first instance share stimulus.
// Expected serial streams are hand-derived; parity builds append the XOR of the word.
module tb_shift_feeder;

`ifdef SHIFT_FEEDER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB_EXP = PAR ? 9 : 8;

  logic       C = 1'b0;
  logic       CLR_N;
  logic [7:0] D;
  logic       VALID;
  logic       CE;
  logic       so_m, sov_m, ready_m, busy_m, done_m;
  logic       so_l, sov_l, ready_l, busy_l, done_l;

  int errors = 0;
  int checks = 0;

  always #5 C = ~C;

  shift_feeder #(.NBITS(8), .MSB_FIRST(1'b1)) u_msb (
    .C(C), .CLR_N(CLR_N), .D(D), .VALID(VALID), .READY(ready_m), .CE(CE),
    .SO(so_m), .SO_VALID(sov_m), .BUSY(busy_m), .DONE(done_m)
  );

  shift_feeder #(.NBITS(8), .MSB_FIRST(1'b0)) u_lsb (
    .C(C), .CLR_N(CLR_N), .D(D), .VALID(VALID), .READY(ready_l), .CE(CE),
    .SO(so_l), .SO_VALID(sov_l), .BUSY(busy_l), .DONE(done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Expected stream as seen by a shift-left register, with the parity bit appended when enabled.
  function automatic logic [31:0] with_par(input logic [15:0] stream, input logic [7:0] d);
    return PAR ? {15'd0, stream, ^d} : {16'd0, stream};
  endfunction

  // Optionally performs the handshake, then applies the repeating CE pattern
  // (bit 0 first) until DONE, assembling the SO stream of the selected instance.
  task automatic collect(input bit sel, input bit do_hs, input logic [7:0] d,
                         input bit hold_valid, input logic [7:0] d_after,
                         input logic [3:0] cepat, output int nvalid,
                         output logic [15:0] sh, output int done_at,
                         output int first_at, output int hold_err);
    logic prev_so;
    logic so_s, sov_s, done_s;
    bit   ce_used;
    nvalid = 0; sh = '0; done_at = -1; first_at = -1; hold_err = 0;
    if (do_hs) begin
      D = d; VALID = 1'b1; CE = 1'b1;
      tick();
    end
    VALID = hold_valid;
    D = d_after;
    prev_so = sel ? so_l : so_m;
    for (int t = 1; t <= 40; t++) begin
      ce_used = cepat[(t - 1) % 4];
      CE = ce_used;
      tick();
      so_s   = sel ? so_l : so_m;
      sov_s  = sel ? sov_l : sov_m;
      done_s = sel ? done_l : done_m;
      if (sov_s) begin
        if (!ce_used) hold_err++;
        nvalid++;
        sh = {sh[14:0], so_s};
        if (first_at < 0) first_at = t;
      end else if (so_s !== prev_so) begin
        hold_err++;
      end
      prev_so = so_s;
      if (done_s) begin
        done_at = nvalid;
        break;
      end
    end
    CE = 1'b1;
  endtask

  int          nv, da, fa, he, stray;
  logic [15:0] sh;

  initial begin
    CLR_N = 1'b0; D = '0; VALID = 1'b0; CE = 1'b0;
    #2;
    check("rst_ready", ready_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_so", so_m, 0);
    check("rst_so_valid", sov_m, 0);
    check("rst_done", done_m, 0);
    #10 CLR_N = 1'b1;

    // A5, MSB first, CE high
    collect(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 4'hF, nv, sh, da, fa, he);
    check("a5_count", nv, NB_EXP);
    check("a5_stream", {16'd0, sh}, with_par(16'h00A5, 8'hA5));
    check("a5_done_at", da, NB_EXP);
    check("a5_latency", fa, 1);
    check("a5_ready_at_done", ready_m, 1);

    // 01, LSB first instance: 1 then seven 0s
    collect(1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 4'hF, nv, sh, da, fa, he);
    check("lsb01_count", nv, NB_EXP);
    check("lsb01_stream", {16'd0, sh}, with_par(16'h0080, 8'h01));
    check("lsb01_done_at", da, NB_EXP);
    check("lsb01_ready_at_done", ready_l, 1);
    tick();
    check("lsb01_ready_after", ready_l, 1);

    // F0 with CE pattern 1,0,0,1
    collect(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 4'b1001, nv, sh, da, fa, he);
    check("f0ce_count", nv, NB_EXP);
    check("f0ce_stream", {16'd0, sh}, with_par(16'h00F0, 8'hF0));
    check("f0ce_hold_err", he, 0);

    // VALID held: 3C sent, C3 presented while busy must wait
    collect(1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3, 4'hF, nv, sh, da, fa, he);
    check("3c_stream", {16'd0, sh}, with_par(16'h003C, 8'h3C));
    check("3c_ready_at_done", ready_m, 1);
    tick();
    check("c3_accepted", busy_m, 1);
    collect(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'hF, nv, sh, da, fa, he);
    check("c3_stream", {16'd0, sh}, with_par(16'h00C3, 8'hC3));
    check("c3_latency", fa, 1);

    // Parity vectors (plain data in the default build)
    collect(1'b0, 1'b1, 8'h07, 1'b0, 8'h00, 4'hF, nv, sh, da, fa, he);
    check("07_stream", {16'd0, sh}, PAR ? 32'h00F : 32'h007);
    collect(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 4'hF, nv, sh, da, fa, he);
    check("03_stream", {16'd0, sh}, PAR ? 32'h006 : 32'h003);

    // Reset after 3 bits of FF
    D = 8'hFF; VALID = 1'b1; CE = 1'b1;
    tick();
    VALID = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!sov_m) stray++;
    end
    check("ff_three_bits", stray, 0);
    CLR_N = 1'b0;
    #1;
    check("midrst_so", so_m, 0);
    check("midrst_so_valid", sov_m, 0);
    check("midrst_ready", ready_m, 1);
    check("midrst_busy", busy_m, 0);
    stray = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (sov_m || done_m || sov_l || done_l) stray++;
    end
    @(negedge C);
    CLR_N = 1'b1;
    D = 8'h55; VALID = 1'b1;
    for (int i = 0; i < 1; i++) begin
      tick();
      if (sov_m || done_m) stray++;
    end
    check("midrst_no_stray", stray, 0);
    check("first_hs_after_rst", busy_m, 1);
    collect(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'hF, nv, sh, da, fa, he);
    check("55_stream", {16'd0, sh}, with_par(16'h0055, 8'h55));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_feeder.md
SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, meaning the word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 sends D[NBITS-1] first and 0 sends D[0] first.
REQ-003 Port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port CLR_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port D, input, NBITS bits: parallel word, sampled only on handshake.
REQ-006 Port VALID, input, 1 bit: D holds a word to send.
REQ-007 Port READY, output, 1 bit: block can accept a word this cycle.
REQ-008 Port CE, input, 1 bit: bit strobe; one serial bit is emitted per CE-high cycle while busy.
REQ-009 Port SO, output, 1 bit: registered serial data, for the SI of a downstream shift register.
REQ-010 Port SO_VALID, output, 1 bit: registered one-cycle qualifier, high in each cycle SO carries a new bit.
REQ-011 Port BUSY, output, 1 bit: high while a word is in flight.
REQ-012 Port DONE, output, 1 bit: one-cycle pulse, coincident with SO_VALID of the final bit of a word.

Function
REQ-013 The FSM SHALL have states IDLE and SHIFT, plus PARITY when SHIFT_FEEDER_PARITY_EN is defined.
REQ-014 READY SHALL equal (state==IDLE), combinationally; BUSY SHALL equal its inverse.
REQ-015 In IDLE with VALID&READY at an edge: capture D into the internal shift register, clear the bit counter, and go to SHIFT.
REQ-016 In SHIFT, at an edge with CE=1: output the selected end bit to SO, set SO_VALID=1, shift the register one place toward that end, and increment the counter.
REQ-017 At any edge with CE=0 (or in IDLE): SO SHALL hold its value and SO_VALID SHALL be 0.
REQ-018 On the CE edge where the counter reaches NBITS-1: set DONE=1 (when no parity) and move to IDLE (or PARITY).
REQ-019 Latency from handshake edge to first SO_VALID SHALL be 1 CE edge. With CE tied high, one word SHALL take NBITS+1 cycles (handshake cycle + NBITS bits), so back-to-back words leave one idle cycle between them.
REQ-020 VALID while READY=0 SHALL be ignored. D changes after the handshake SHALL NOT affect the word in flight.
REQ-021 The counter SHALL be $clog2(NBITS+1) bits wide and SHALL NOT wrap within a word.

Reset
REQ-022 When CLR_N=0, asynchronously: state=IDLE, shift register=0, counter=0, SO=0, SO_VALID=0, DONE=0; hence READY=1 and BUSY=0.
REQ-023 Reset asserted mid-word SHALL discard the word; no further SO_VALID or DONE SHALL occur for it.
REQ-024 The first handshake SHALL be possible at the first rising edge of C after CLR_N rises.

Configuration
REQ-025 With macro SHIFT_FEEDER_PARITY_EN defined: after the last data bit, state PARITY SHALL emit, on the next CE edge, the even-parity bit (XOR of the captured word) with SO_VALID=1 and DONE=1, then return to IDLE; a word then takes NBITS+2 cycles.
REQ-026 With SHIFT_FEEDER_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DONE SHALL accompany the last data bit.

Structure
REQ-027 Package shift_feeder_pkg SHALL hold the state enum type (IDLE, SHIFT, PARITY) and the default-width constant.
REQ-028 The bit counter with its terminal-count compare SHALL be sub-module shift_feeder_bitcnt; everything else stays in shift_feeder.

Verification
REQ-029 NBITS=8, MSB_FIRST=1, CE=1, D=8'hA5: SO over 8 SO_VALID cycles = 1,0,1,0,0,1,0,1; DONE on the 8th; an 8-bit shift-left register clocked by SO_VALID holds 8'hA5.
REQ-030 MSB_FIRST=0, D=8'h01: first SO=1, then seven 0s; READY returns 1 the cycle after DONE.
REQ-031 CE pattern 1,0,0,1 during SHIFT with D=8'hF0: SO_VALID low on the CE=0 cycles, SO held; exactly 8 SO_VALID pulses total.
REQ-032 VALID held high with D=8'h3C, then 8'hC3 presented while BUSY: only 8'h3C sent; 8'hC3 accepted at the next READY=1 edge.
REQ-033 CLR_N pulsed low after 3 bits of 8'hFF: SO=0, SO_VALID=0, READY=1 immediately; no DONE.
REQ-034 With SHIFT_FEEDER_PARITY_EN, D=8'h07: ninth SO_VALID carries SO=1 with DONE; with D=8'h03 it carries SO=0.
